// File: rtl/ctrl_executor.sv
// Control-word executor: latches one decoded control word and sequences
// ALU, memory and register-file strobes through EXEC/MEM/WB.
module ctrl_executor #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_valid,
    input  logic [7:0]  ctrl_in,
    output logic        ctrl_ready,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        alu_en,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        pc_src,
    output logic        done,
    output logic        illegal,
    output logic        mem_err,
    output logic [15:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM,
        WB
    } state_t;

    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [7:0]  word;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [15:0] cnt;

    logic w_alusrc, w_memtoreg, w_regwrite, w_memread, w_memwrite, w_branch;
    logic [1:0] w_aluop;
    logic       w_illegal;

    logic rdy_c, en_c, rd_c, wr_c, we_c, sel_c, pc_c, dn_c, ill_c, err_c;
    logic src_c;
    logic [1:0] op_c;

    assign w_alusrc   = word[7];
    assign w_memtoreg = word[6];
    assign w_regwrite = word[5];
    assign w_memread  = word[4];
    assign w_memwrite = word[3];
    assign w_branch   = word[2];
    assign w_aluop    = word[1:0];
    assign w_illegal  = (w_aluop == 2'b11) | (w_memread & w_memwrite);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word     <= '0;
            wait_cnt <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == IDLE && ctrl_valid) begin
                word <= ctrl_in;
            end
            if (dn_c) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        rdy_c     = 1'b0;
        en_c      = 1'b0;
        src_c     = 1'b0;
        op_c      = 2'b00;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        we_c      = 1'b0;
        sel_c     = 1'b0;
        pc_c      = 1'b0;
        dn_c      = 1'b0;
        ill_c     = 1'b0;
        err_c     = 1'b0;
        case (state)
            IDLE: begin
                rdy_c    = 1'b1;
                wait_nxt = '0;
                if (ctrl_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                en_c     = 1'b1;
                src_c    = w_alusrc;
                op_c     = w_aluop;
                wait_nxt = 8'd1;
                if (w_illegal) begin
                    ill_c     = 1'b1;
                    state_nxt = IDLE;
                end else if (w_branch) begin
                    pc_c      = alu_zero;
                    dn_c      = 1'b1;
                    state_nxt = IDLE;
                end else if (w_memread | w_memwrite) begin
                    state_nxt = MEM;
                end else if (w_regwrite) begin
                    state_nxt = WB;
                end else begin
                    dn_c      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            MEM: begin
                rd_c = w_memread;
                wr_c = w_memwrite;
                // done retires in the ack cycle itself when there is no write-back
                if (mem_ack) begin
                    if (w_regwrite) begin
                        state_nxt = WB;
                    end else begin
                        dn_c      = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (wait_cnt == TO8) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            WB: begin
                we_c      = 1'b1;
                sel_c     = w_memtoreg;
                dn_c      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is forced low while reset is held, even before the reset edge.
    assign ctrl_ready  = rdy_c & ~rst;
    assign alu_en      = en_c & ~rst;
    assign alu_src     = src_c & ~rst;
    assign alu_op      = op_c & {2{~rst}};
    assign mem_rd      = rd_c & ~rst;
    assign mem_wr      = wr_c & ~rst;
    assign reg_we      = we_c & ~rst;
    assign wb_sel      = sel_c & ~rst;
    assign pc_src      = pc_c & ~rst;
    assign done        = dn_c & ~rst;
    assign illegal     = ill_c & ~rst;
    assign mem_err     = err_c & ~rst;
    assign retired_cnt = rst ? '0 : cnt;

endmodule

// File: tb/tb_ctrl_executor.sv
// Directed bench for ctrl_executor: a per-transaction trace model predicts
// every cycle's outputs; one negedge process compares the DUT against it.
module tb_ctrl_executor;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_valid = 1'b0;
    logic [7:0]  ctrl_in = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ctrl_ready, alu_en, alu_src, mem_rd, mem_wr, reg_we, wb_sel;
    logic        pc_src, done, illegal, mem_err;
    logic [1:0]  alu_op;
    logic [15:0] retired_cnt;

    ctrl_executor #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_valid  (ctrl_valid),
        .ctrl_in     (ctrl_in),
        .ctrl_ready  (ctrl_ready),
        .alu_zero    (alu_zero),
        .mem_ack     (mem_ack),
        .alu_en      (alu_en),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .pc_src      (pc_src),
        .done        (done),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, en, src;
        logic [1:0]  op;
        logic        rd, wr, we, sel, pc, dn, ill, err;
        logic        rst;
        logic        setc;
        logic [15:0] cval;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        trace[$];
    exp_t        ce;
    int          n_pass = 0;
    int          n_chk = 0;
    int          cyc = 0;
    logic [15:0] model_cnt = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic logic [12:0] pack(input exp_t e);
        return {e.rdy, e.en, e.src, e.op, e.rd, e.wr, e.we, e.sel, e.pc, e.dn, e.ill, e.err};
    endfunction

    // Cycle-by-cycle outputs of one instruction, starting with the handshake cycle.
    function automatic void build(input logic [7:0] w, input logic z, input int ack);
        exp_t e;
        logic rd, wr;
        rd = w[4];
        wr = w[3];
        trace.delete();
        e = blank(); e.rdy = 1'b1; trace.push_back(e);
        e = blank(); e.en = 1'b1; e.src = w[7]; e.op = w[1:0];
        if (w[1:0] == 2'b11 || (rd && wr)) begin e.ill = 1'b1; trace.push_back(e); return; end
        if (w[2]) begin e.pc = z; e.dn = 1'b1; trace.push_back(e); return; end
        if (!rd && !wr && !w[5]) begin e.dn = 1'b1; trace.push_back(e); return; end
        trace.push_back(e);
        if (rd || wr) begin
            for (int k = 1; k <= TO; k++) begin
                e = blank(); e.rd = rd; e.wr = wr;
                if (k == ack) begin
                    if (!w[5]) begin e.dn = 1'b1; trace.push_back(e); return; end
                    trace.push_back(e);
                    break;
                end
                if (k == TO) begin e.err = 1'b1; trace.push_back(e); return; end
                trace.push_back(e);
            end
        end
        e = blank(); e.we = 1'b1; e.sel = w[6]; e.dn = 1'b1; trace.push_back(e);
    endfunction

    function automatic int count_rd();
        int c = 0;
        foreach (trace[j]) if (trace[j].rd) c++;
        return c;
    endfunction

    function automatic int count_wr();
        int c = 0;
        foreach (trace[j]) if (trace[j].wr) c++;
        return c;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) ce = exp_q.pop_front();
        else begin ce = blank(); ce.rdy = 1'b1; end
        if (ce.setc) model_cnt = ce.cval;
        if (ce.rst) model_cnt = '0;
        chk($sformatf("cyc%0d outputs", cyc),
            {ctrl_ready, alu_en, alu_src, alu_op, mem_rd, mem_wr, reg_we, wb_sel, pc_src, done, illegal, mem_err},
            pack(ce));
        chk($sformatf("cyc%0d retired_cnt", cyc), retired_cnt, model_cnt);
        if (ce.dn) model_cnt = model_cnt + 16'd1;
    end

    task automatic reset_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; ctrl_valid = 1'b0; mem_ack = 1'b0;
            e = blank(); e.rst = 1'b1; exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b0; ctrl_valid = 1'b0;
            ctrl_in = 8'($urandom); mem_ack = 1'($urandom); alu_zero = 1'($urandom);
        end
    endtask

    // abort_at > 0 keeps that many trace cycles, then holds rst for two cycles.
    task automatic run_tx(input logic [7:0] w, input logic z, input int ack, input bit stray, input int abort_at);
        exp_t e;
        int n;
        build(w, z, ack);
        if (abort_at > 0) begin
            while (trace.size() > abort_at) void'(trace.pop_back());
            e = blank(); e.rst = 1'b1;
            trace.push_back(e);
            trace.push_back(e);
        end
        n = trace.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) foreach (trace[j]) exp_q.push_back(trace[j]);
            rst        = trace[i].rst;
            ctrl_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ctrl_in    = (i == 0) ? w : 8'($urandom);
            mem_ack    = ((ack > 0) && (i == ack + 1)) || (stray && i <= 1);
            alu_zero   = z;
        end
    endtask

    task automatic preload(input logic [15:0] v);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b0; ctrl_valid = 1'b0; mem_ack = 1'b0;
        force dut.cnt = v;
        e = blank(); e.rdy = 1'b1; e.setc = 1'b1; e.cval = v;
        exp_q.push_back(e);
        @(negedge clk); #1;
        release dut.cnt;
    endtask

    task automatic pin_cnt(input string name, input logic [15:0] v);
        @(negedge clk); #1;
        chk(name, retired_cnt, v);
    endtask

    initial begin
        reset_cycles(2);
        idle(2);

        run_tx(8'b00100010, 1'b0, 0, 1'b1, 0);          // R-type, stray acks
        chk("rtype_len", trace.size(), 3);
        chk("rtype_wb", {trace[2].we, trace[2].sel, trace[2].dn}, 3'b101);
        idle(1);
        pin_cnt("rtype_cnt", 16'd1);

        run_tx(8'b11110000, 1'b0, 3, 1'b0, 0);          // load, ack on 3rd MEM cycle
        chk("load3_rd_cycles", count_rd(), 3);
        chk("load3_wb", {trace[5].we, trace[5].sel, trace[5].dn}, 3'b111);
        run_tx(8'b11110000, 1'b1, 1, 1'b0, 0);          // load, immediate ack
        chk("load1_rd_at_n2", trace[2].rd, 1);
        chk("load1_we_at_n3", trace[3].we, 1);
        run_tx(8'b10001000, 1'b0, 1, 1'b0, 0);          // store, immediate ack
        chk("store1_done_n2", {trace[2].wr, trace[2].dn}, 2'b11);
        run_tx(8'b00000101, 1'b1, 0, 1'b0, 0);          // branch taken
        chk("br_taken", {trace[1].pc, trace[1].dn}, 2'b11);
        run_tx(8'b00000101, 1'b0, 0, 1'b0, 0);          // branch not taken
        run_tx(8'b00000000, 1'b0, 0, 1'b0, 0);          // no-op
        run_tx(8'b10001000, 1'b0, 0, 1'b0, 0);          // store timeout
        chk("to_wr_cycles", count_wr(), 16);
        chk("to_err_cycle", {trace[17].err, trace[17].dn}, 2'b10);
        run_tx(8'b00000011, 1'b0, 0, 1'b0, 0);          // illegal ALUOp
        run_tx(8'b00011000, 1'b0, 1, 1'b0, 0);          // illegal MemRead&MemWrite
        chk("ill_pulse", {trace[1].ill, trace[1].dn, trace[1].en}, 3'b101);
        idle(1);
        pin_cnt("after_illegal_cnt", 16'd7);

        run_tx(8'b11110000, 1'b0, 0, 1'b0, 4);          // reset during MEM of a load
        idle(2);
        pin_cnt("after_abort_cnt", 16'd0);

        idle(1);
        preload(16'hFFFD);
        run_tx(8'b00000000, 1'b0, 0, 1'b0, 0);
        run_tx(8'b00000000, 1'b0, 0, 1'b0, 0);
        idle(1);
        pin_cnt("near_wrap_cnt", 16'hFFFF);
        run_tx(8'b00100010, 1'b0, 0, 1'b0, 0);
        idle(1);
        pin_cnt("wrap_cnt", 16'd0);
        idle(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
